// File: rtl/conv_stream_host.sv
// conv_stream_host
//   Stream initiator/collector for the system side of a convolver's
//   valid/ready interface. One X vector and one F vector are loaded through
//   a config write port. A start pulse streams both vectors out on two
//   independent channels. The NUM_Y results that come back are captured into
//   a result buffer, which is read through a registered read port.
//
// Handshake rule (all three channels): a beat transfers on a rising edge
// where valid && ready. A source never changes data or drops valid while
// valid && !ready. Each valid and each ready is a function of registered
// state only. No valid or ready depends combinationally on its partner.
//
// Optional build macro: STALL_INJECT_EN
//   When defined, an 8-bit LFSR throttles new X/F beats and y_ready so that
//   the convolver is exercised with irregular traffic.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cfg_wr_en/sel/addr/data  write into X (sel=0) or F (sel=1) buffer; ignored while busy
//   start                one-cycle pulse, accepted only in IDLE
//   busy, done           run in progress / one-cycle completion pulse
//   x_data/x_valid/x_ready   X sample stream out
//   f_data/f_valid/f_ready   F sample stream out
//   y_data/y_valid/y_ready   result stream in
//   res_addr, res_data   result read port, data one cycle after address
//   dbg_state            current FSM state (0 IDLE, 1 RUN, 2 FINISH)
module conv_stream_host #(
  parameter int WIDTH     = 10,
  parameter int OUT_WIDTH = 23,
  parameter int SIZE_X    = 12,
  parameter int SIZE_F    = 5,
  localparam int NUM_Y    = SIZE_X - SIZE_F + 1,
  localparam int AW       = (SIZE_X > 1) ? $clog2(SIZE_X) : 1,
  localparam int RA_W     = (NUM_Y > 1) ? $clog2(NUM_Y) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_wr_en,
  input  logic                 cfg_sel,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [WIDTH-1:0]     cfg_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     x_data,
  output logic                 x_valid,
  input  logic                 x_ready,
  output logic [WIDTH-1:0]     f_data,
  output logic                 f_valid,
  input  logic                 f_ready,
  input  logic [OUT_WIDTH-1:0] y_data,
  input  logic                 y_valid,
  output logic                 y_ready,
  input  logic [RA_W-1:0]      res_addr,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic [1:0]           dbg_state
);

  localparam int XC_W = $clog2(SIZE_X + 1);
  localparam int FC_W = $clog2(SIZE_F + 1);
  localparam int YC_W = $clog2(NUM_Y + 1);
  localparam int FI_W = (SIZE_F > 1) ? $clog2(SIZE_F) : 1;

  localparam logic [XC_W-1:0] X_END = XC_W'(SIZE_X);
  localparam logic [FC_W-1:0] F_END = FC_W'(SIZE_F);
  localparam logic [YC_W-1:0] Y_END = YC_W'(NUM_Y);
  // One extra bit so the limit itself is representable when a size is a power of two.
  localparam logic [AW:0]     X_LIM = (AW + 1)'(SIZE_X);
  localparam logic [AW:0]     F_LIM = (AW + 1)'(SIZE_F);
  localparam logic [RA_W:0]   Y_LIM = (RA_W + 1)'(NUM_Y);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XC_W-1:0] x_cnt_q, x_cnt_d;
  logic [FC_W-1:0] f_cnt_q, f_cnt_d;
  logic [YC_W-1:0] y_cnt_q, y_cnt_d;
  logic [OUT_WIDTH-1:0] res_q;

  logic [WIDTH-1:0]     xbuf_q [SIZE_X];
  logic [WIDTH-1:0]     fbuf_q [SIZE_F];
  logic [OUT_WIDTH-1:0] rbuf_q [NUM_Y];

  logic run;
  logic x_more, f_more, y_more;
  logic x_fire, f_fire, y_fire;

  assign run    = (state_q == S_RUN);
  assign x_more = (x_cnt_q != X_END);
  assign f_more = (f_cnt_q != F_END);
  assign y_more = (y_cnt_q != Y_END);

`ifdef STALL_INJECT_EN
  // Fibonacci LFSR x^8+x^6+x^5+x^4+1. A "hold" flag keeps a raised valid
  // asserted until it is accepted, whatever the LFSR does meanwhile.
  logic [7:0] lfsr_q, lfsr_d;
  logic       x_hold_q, x_hold_d;
  logic       f_hold_q, f_hold_d;

  assign x_valid = run && x_more && (!lfsr_q[0] || x_hold_q);
  assign f_valid = run && f_more && (!lfsr_q[1] || f_hold_q);
  assign y_ready = run && y_more && !lfsr_q[2];

  always_comb begin
    lfsr_d   = lfsr_q;
    x_hold_d = x_valid && !x_ready;
    f_hold_d = f_valid && !f_ready;
    if (run) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q   <= 8'hA5;
      x_hold_q <= 1'b0;
      f_hold_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      x_hold_q <= x_hold_d;
      f_hold_q <= f_hold_d;
    end
  end
`else
  assign x_valid = run && x_more;
  assign f_valid = run && f_more;
  assign y_ready = run && y_more;
`endif

  assign x_fire = x_valid && x_ready;
  assign f_fire = f_valid && f_ready;
  assign y_fire = y_valid && y_ready;

  // Sample presented is picked straight from the counter, so it cannot move
  // while a beat is stalled.
  assign x_data = x_more ? xbuf_q[x_cnt_q[AW-1:0]] : '0;
  assign f_data = f_more ? fbuf_q[f_cnt_q[FI_W-1:0]] : '0;

  assign res_data  = res_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    f_cnt_d = f_cnt_q;
    y_cnt_d = y_cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          x_cnt_d = '0;
          f_cnt_d = '0;
          y_cnt_d = '0;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (x_fire) x_cnt_d = x_cnt_q + XC_W'(1);
        if (f_fire) f_cnt_d = f_cnt_q + FC_W'(1);
        if (y_fire) y_cnt_d = y_cnt_q + YC_W'(1);
        if (!x_more && !f_more && !y_more) state_d = S_FINISH;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_cnt_q <= '0;
      f_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      x_cnt_q <= x_cnt_d;
      f_cnt_q <= f_cnt_d;
      y_cnt_q <= y_cnt_d;
    end
  end

  // Buffer contents survive reset on purpose: a reset between runs keeps
  // the loaded vectors and the last results.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && !busy) begin
      if (!cfg_sel && ({1'b0, cfg_addr} < X_LIM)) xbuf_q[cfg_addr] <= cfg_data;
      if (cfg_sel && ({1'b0, cfg_addr} < F_LIM))  fbuf_q[cfg_addr[FI_W-1:0]] <= cfg_data;
    end
    if (y_fire) rbuf_q[y_cnt_q[RA_W-1:0]] <= y_data;
  end

  // Registered read. A same-cycle write to the addressed entry is seen on
  // the following read, not this one.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
    end else if ({1'b0, res_addr} < Y_LIM) begin
      res_q <= rbuf_q[res_addr];
    end else begin
      res_q <= '0;
    end
  end

endmodule

// File: tb/tb_conv_stream_host.sv
module tb_conv_stream_host;
  localparam int WIDTH     = 10;
  localparam int OUT_WIDTH = 23;
  localparam int SIZE_X    = 12;
  localparam int SIZE_F    = 5;
  localparam int NUM_Y     = SIZE_X - SIZE_F + 1;
  localparam int AW        = 4;
  localparam int RA_W      = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                 cfg_wr_en = 1'b0;
  logic                 cfg_sel = 1'b0;
  logic [AW-1:0]        cfg_addr = '0;
  logic [WIDTH-1:0]     cfg_data = '0;
  logic                 start = 1'b0;
  logic                 busy, done;
  logic [WIDTH-1:0]     x_data, f_data;
  logic                 x_valid, f_valid, y_ready;
  logic                 x_ready = 1'b0;
  logic                 f_ready = 1'b0;
  logic [OUT_WIDTH-1:0] y_data = '0;
  logic                 y_valid = 1'b0;
  logic [RA_W-1:0]      res_addr = '0;
  logic [OUT_WIDTH-1:0] res_data;
  logic [1:0]           dbg_state;

  conv_stream_host #(
    .WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .SIZE_X(SIZE_X), .SIZE_F(SIZE_F)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .busy(busy), .done(done),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .res_addr(res_addr), .res_data(res_data), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // Bench copy of the vectors it loaded, and what it saw on the streams.
  logic [WIDTH-1:0]     xmem [SIZE_X];
  logic [WIDTH-1:0]     fmem [SIZE_F];
  logic [WIDTH-1:0]     x_got[$];
  logic [WIDTH-1:0]     f_got[$];
  logic [OUT_WIDTH-1:0] exp_q[$];

  int   x_first, x_last, f_first, f_last, y_beats, done_cnt, bad_busy;
  int   vdrop, stall_bad, y_late, y_refused, timeout, y_rdy_early;
  logic post_busy, post_xv, post_fv, post_yr;

  // Correlation form: y_k = sum_j x[k+j]*f[j]
  function automatic logic [OUT_WIDTH-1:0] conv_got(input int k);
    int acc = 0;
    for (int j = 0; j < SIZE_F; j++) begin
      int xa = $signed(x_got[k+j]);
      int fa = $signed(f_got[j]);
      acc += xa * fa;
    end
    return OUT_WIDTH'(acc);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] conv_mem(input int k);
    int acc = 0;
    for (int j = 0; j < SIZE_F; j++) begin
      int xa = $signed(xmem[k+j]);
      int fa = $signed(fmem[j]);
      acc += xa * fa;
    end
    return OUT_WIDTH'(acc);
  endfunction

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic cfg_write(input logic sel, input int addr, input logic [WIDTH-1:0] data);
    cfg_wr_en = 1'b1; cfg_sel = sel; cfg_addr = AW'(addr); cfg_data = data;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic load_vectors();
    for (int i = 0; i < SIZE_X; i++) cfg_write(1'b0, i, xmem[i]);
    for (int i = 0; i < SIZE_F; i++) cfg_write(1'b1, i, fmem[i]);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic read_res(input int addr, output logic [OUT_WIDTH-1:0] d);
    res_addr = RA_W'(addr);
    @(negedge clk);
    d = res_data;
  endtask

  // Convolver-side agent for one run.
  //   xmode: 0 always ready, 1 stall 3 cycles at beat 4, 2 random, 3 not ready for 15 cycles
  //   fmode: 0 always ready, 1 random
  //   ymode: 0 returns convolution of received samples, 1 offers 9 beats 100+k
  //   rst_at: RUN cycle to assert reset (-1 none); poke_at: cycle for cfg write + start (-1 none)
  task automatic run_dut(input int xmode, input int fmode, input int ymode,
                         input int rst_at, input int poke_at);
    int   stall_n = 0;
    int   y_idx = 0;
    logic y_hold = 1'b0;
    logic pxv = 1'b0, pxr = 1'b0, pfv = 1'b0, pfr = 1'b0;
    logic [WIDTH-1:0] pxd = '0, pfd = '0;
    x_got.delete(); f_got.delete();
    x_first = -1; x_last = -1; f_first = -1; f_last = -1;
    y_beats = 0; done_cnt = 0; bad_busy = 0; vdrop = 0; stall_bad = 0;
    y_late = 0; y_refused = 0; timeout = 1; y_rdy_early = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin
        done_cnt++;
        if (busy) bad_busy++;
      end
      if (pxv && !pxr && (x_valid !== 1'b1 || x_data !== pxd)) vdrop++;
      if (pfv && !pfr && (f_valid !== 1'b1 || f_data !== pfd)) vdrop++;
      if (cyc == rst_at) begin
        reset = 1'b1; x_ready = 1'b0; f_ready = 1'b0; y_valid = 1'b0;
        @(negedge clk);
        post_busy = busy; post_xv = x_valid; post_fv = f_valid; post_yr = y_ready;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (done) done_cnt++;
          @(negedge clk);
        end
        timeout = 0;
        return;
      end
      if (done) begin
        x_ready = 1'b0; f_ready = 1'b0; y_valid = 1'b0;
        timeout = 0;
        @(negedge clk);
        if (done) done_cnt++;
        return;
      end
      cfg_wr_en = (cyc == poke_at);
      start     = (cyc == poke_at);
      cfg_sel   = 1'b0; cfg_addr = '0; cfg_data = '1;
      case (xmode)
        0: x_ready = 1'b1;
        1: begin
          if (x_got.size() == 4 && stall_n < 3) begin
            x_ready = 1'b0;
            stall_n++;
            if (x_valid !== 1'b1 || x_data !== xmem[4]) stall_bad++;
          end else begin
            x_ready = 1'b1;
          end
        end
        2: x_ready = 1'($urandom_range(0, 1));
        default: x_ready = (cyc >= 15);
      endcase
      f_ready = (fmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (ymode == 0) begin
        if (!y_hold && y_idx < NUM_Y && x_got.size() >= y_idx + SIZE_F &&
            f_got.size() == SIZE_F && (fmode == 0 || $urandom_range(0, 1) == 1)) begin
          y_hold = 1'b1;
          y_data = conv_got(y_idx);
        end
        y_valid = y_hold;
      end else begin
        y_valid = (y_idx <= NUM_Y);
        y_data  = OUT_WIDTH'(100 + y_idx);
        if (y_idx == NUM_Y && busy && y_ready) y_late++;
        if (y_idx == NUM_Y && y_valid && !y_ready) y_refused++;
      end
      if (y_ready && x_got.size() < SIZE_X) y_rdy_early = 1;
      if (y_valid && y_ready) begin
        y_idx++; y_beats++; y_hold = 1'b0;
      end
      pxv = x_valid; pxr = x_ready; pxd = x_data;
      pfv = f_valid; pfr = f_ready; pfd = f_data;
      if (x_valid && x_ready) begin
        x_got.push_back(x_data);
        if (x_first < 0) x_first = cyc;
        x_last = cyc;
      end
      if (f_valid && f_ready) begin
        f_got.push_back(f_data);
        if (f_first < 0) f_first = cyc;
        f_last = cyc;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (x_valid !== 1'b0) begin failures++; $display("FAIL reset_x_valid got=%0b exp=0", x_valid); end
    checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL reset_f_valid got=%0b exp=0", f_valid); end
    checks++; if (y_ready !== 1'b0) begin failures++; $display("FAIL reset_y_ready got=%0b exp=0", y_ready); end
    checks++; if (res_data !== '0) begin failures++; $display("FAIL reset_res_data got=%0d exp=0", res_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [OUT_WIDTH-1:0] d;
    int bad = 0;
    for (int i = 0; i < SIZE_X; i++) xmem[i] = WIDTH'(i + 1);
    for (int i = 0; i < SIZE_F; i++) fmem[i] = (i == 0) ? WIDTH'(1) : WIDTH'(0);
    load_vectors();
    do_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_after_start got=%0b exp=1", busy); end
    run_dut(0, 0, 0, -1, -1);
    checks++; if (timeout !== 0) begin failures++; $display("FAIL basic_timeout got=%0d exp=0", timeout); end
    checks++; if (x_got.size() !== SIZE_X) begin failures++; $display("FAIL basic_x_beats got=%0d exp=%0d", x_got.size(), SIZE_X); end
    checks++; if (x_first !== 0 || x_last !== SIZE_X - 1) begin failures++; $display("FAIL basic_x_back_to_back got=%0d..%0d exp=0..%0d", x_first, x_last, SIZE_X - 1); end
    checks++; if (f_got.size() !== SIZE_F) begin failures++; $display("FAIL basic_f_beats got=%0d exp=%0d", f_got.size(), SIZE_F); end
    checks++; if (f_first !== 0 || f_last !== SIZE_F - 1) begin failures++; $display("FAIL basic_f_back_to_back got=%0d..%0d exp=0..%0d", f_first, f_last, SIZE_F - 1); end
    for (int i = 0; i < x_got.size() && i < SIZE_X; i++) if (x_got[i] !== WIDTH'(i + 1)) bad++;
    for (int i = 0; i < f_got.size() && i < SIZE_F; i++) if (f_got[i] !== fmem[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL basic_sample_order got=%0d wrong exp=0", bad); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (bad_busy !== 0) begin failures++; $display("FAIL basic_busy_with_done got=%0d exp=0", bad_busy); end
    checks++; if (y_rdy_early !== 1) begin failures++; $display("FAIL basic_y_ready_early got=%0d exp=1", y_rdy_early); end
    checks++; if (y_beats !== NUM_Y) begin failures++; $display("FAIL basic_y_beats got=%0d exp=%0d", y_beats, NUM_Y); end
    exp_q.delete();
    for (int k = 0; k < NUM_Y; k++) exp_q.push_back(OUT_WIDTH'(k + 1));
    for (int k = 0; k < NUM_Y; k++) begin
      read_res(k, d);
      checks++; if (d !== exp_q[k]) begin failures++; $display("FAIL basic_rbuf[%0d] got=%0d exp=%0d", k, d, exp_q[k]); end
    end
  endtask

  task automatic test_x_stall();
    int bad = 0;
    do_start();
    run_dut(1, 0, 0, -1, -1);
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL stall_x_held got=%0d bad cycles exp=0", stall_bad); end
    checks++; if (vdrop !== 0) begin failures++; $display("FAIL stall_valid_drop got=%0d exp=0", vdrop); end
    checks++; if (x_got.size() !== SIZE_X) begin failures++; $display("FAIL stall_x_beats got=%0d exp=%0d", x_got.size(), SIZE_X); end
    for (int i = 0; i < x_got.size() && i < SIZE_X; i++) if (x_got[i] !== xmem[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL stall_x_order got=%0d wrong exp=0", bad); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_y_overflow();
    logic [OUT_WIDTH-1:0] d;
    do_start();
    run_dut(3, 0, 1, -1, -1);
    checks++; if (timeout !== 0) begin failures++; $display("FAIL yovf_timeout got=%0d exp=0", timeout); end
    checks++; if (y_beats !== NUM_Y) begin failures++; $display("FAIL yovf_y_beats got=%0d exp=%0d", y_beats, NUM_Y); end
    checks++; if (y_late !== 0) begin failures++; $display("FAIL yovf_y_ready_after_last got=%0d exp=0", y_late); end
    checks++; if (y_refused < 1) begin failures++; $display("FAIL yovf_ninth_offered got=%0d exp>=1", y_refused); end
    for (int k = 0; k < NUM_Y; k++) begin
      read_res(k, d);
      checks++; if (d !== OUT_WIDTH'(100 + k)) begin failures++; $display("FAIL yovf_rbuf[%0d] got=%0d exp=%0d", k, d, 100 + k); end
    end
  endtask

  task automatic test_reset_mid_run();
    do_start();
    run_dut(0, 0, 0, 6, -1);
    checks++; if (post_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", post_busy); end
    checks++; if (post_xv !== 1'b0 || post_fv !== 1'b0) begin failures++; $display("FAIL abort_valids got=%0b%0b exp=00", post_xv, post_fv); end
    checks++; if (post_yr !== 1'b0) begin failures++; $display("FAIL abort_y_ready got=%0b exp=0", post_yr); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    do_start();
    run_dut(0, 0, 0, -1, -1);
    checks++; if (x_got.size() !== SIZE_X) begin failures++; $display("FAIL restart_x_beats got=%0d exp=%0d", x_got.size(), SIZE_X); end
    checks++; if (x_got.size() == 0 || x_got[0] !== xmem[0]) begin failures++; $display("FAIL restart_first_x got=%0d exp=%0d", (x_got.size() > 0) ? x_got[0] : 'x, xmem[0]); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_busy_write();
    do_start();
    run_dut(0, 0, 0, -1, 2);
    checks++; if (x_got.size() !== SIZE_X) begin failures++; $display("FAIL busy_start_ignored got=%0d x beats exp=%0d", x_got.size(), SIZE_X); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL busy_done got=%0d exp=1", done_cnt); end
    do_start();
    run_dut(0, 0, 0, -1, -1);
    checks++; if (x_got.size() == 0 || x_got[0] !== xmem[0]) begin failures++; $display("FAIL busy_write_ignored got=%0d exp=%0d", (x_got.size() > 0) ? x_got[0] : 'x, xmem[0]); end
  endtask

  task automatic test_start_with_write();
    xmem[0] = WIDTH'(9);
    cfg_wr_en = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = xmem[0];
    do_start();
    cfg_wr_en = 1'b0;
    run_dut(0, 0, 0, -1, -1);
    checks++; if (x_got.size() == 0 || x_got[0] !== WIDTH'(9)) begin failures++; $display("FAIL start_write_first_x got=%0d exp=9", (x_got.size() > 0) ? x_got[0] : 'x); end
  endtask

  task automatic test_random_ready();
    logic [OUT_WIDTH-1:0] d;
    int bad = 0;
    for (int i = 0; i < SIZE_X; i++) xmem[i] = WIDTH'($urandom_range(0, 1023));
    for (int i = 0; i < SIZE_F; i++) fmem[i] = WIDTH'($urandom_range(0, 1023));
    load_vectors();
    do_start();
    run_dut(2, 1, 0, -1, -1);
    checks++; if (timeout !== 0) begin failures++; $display("FAIL rand_timeout got=%0d exp=0", timeout); end
    checks++; if (x_got.size() !== SIZE_X || f_got.size() !== SIZE_F || y_beats !== NUM_Y) begin
      failures++; $display("FAIL rand_beats got=%0d/%0d/%0d exp=%0d/%0d/%0d", x_got.size(), f_got.size(), y_beats, SIZE_X, SIZE_F, NUM_Y); end
    checks++; if (vdrop !== 0) begin failures++; $display("FAIL rand_valid_drop got=%0d exp=0", vdrop); end
    for (int i = 0; i < x_got.size() && i < SIZE_X; i++) if (x_got[i] !== xmem[i]) bad++;
    for (int i = 0; i < f_got.size() && i < SIZE_F; i++) if (f_got[i] !== fmem[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL rand_sample_order got=%0d wrong exp=0", bad); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rand_done got=%0d exp=1", done_cnt); end
    exp_q.delete();
    for (int k = 0; k < NUM_Y; k++) exp_q.push_back(conv_mem(k));
    for (int k = 0; k < NUM_Y; k++) begin
      read_res(k, d);
      checks++; if (d !== exp_q[k]) begin failures++; $display("FAIL rand_rbuf[%0d] got=%0d exp=%0d", k, d, exp_q[k]); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_x_stall();
    test_y_overflow();
    test_reset_mid_run();
    test_busy_write();
    test_start_with_write();
    test_random_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_stream_host.md
Name: conv_stream_host

Overview:
- Stream initiator/collector for the other end of the convolver's valid/ready interface.
- Holds one X vector (SIZE_X samples) and one F vector (SIZE_F samples) loaded through a config write port.
- On start, transmits X and F as two independent valid/ready streams and receives the NUM_Y = SIZE_X-SIZE_F+1 Y results into a result buffer.
- Results are read back through a registered read port; used as the system-side driver for convolution blocks and as a reusable bench agent.

Parameters:
- WIDTH, 10, bit width of x_data, f_data and cfg_data.
- OUT_WIDTH, 23, bit width of y_data and res_data.
- SIZE_X, 12, samples per X vector.
- SIZE_F, 5, samples per F vector; must satisfy 1 <= SIZE_F <= SIZE_X.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_wr_en  in  1  write strobe for the X/F buffers.
- cfg_sel  in  1  0 selects the X buffer, 1 selects the F buffer.
- cfg_addr  in  $clog2(SIZE_X)  write index.
- cfg_data  in  WIDTH  signed sample to write.
- start  in  1  one-cycle pulse that begins a run.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- x_data  out  WIDTH  signed X sample on the stream.
- x_valid  out  1  X beat valid.
- x_ready  in  1  X beat accepted by the convolver.
- f_data  out  WIDTH  signed F sample on the stream.
- f_valid  out  1  F beat valid.
- f_ready  in  1  F beat accepted by the convolver.
- y_data  in  OUT_WIDTH  signed result from the convolver.
- y_valid  in  1  result valid.
- y_ready  out  1  result accepted by this block.
- res_addr  in  $clog2(NUM_Y)  result read index.
- res_data  out  OUT_WIDTH  result buffer contents at res_addr, one cycle after res_addr.

Behaviour:
- Reset values: busy=0, done=0, x_valid=0, f_valid=0, y_ready=0, all counters=0, res_data=0. The X, F and result buffers are not cleared by reset.
- Buffers are flop arrays.
  - Config write: when cfg_wr_en=1 and busy=0, write cfg_data to buffer[cfg_addr] selected by cfg_sel.
  - Ignore writes when busy=1, when the F address is >= SIZE_F, or when the X address is >= SIZE_X.
- FSM states IDLE, RUN, FINISH.
  - IDLE: start=1 -> RUN; clear x_cnt, f_cnt, y_cnt; busy=1 from the next cycle.
  - RUN: exit to FINISH when x_cnt==SIZE_X, f_cnt==SIZE_F and y_cnt==NUM_Y all hold.
  - FINISH: lasts one cycle with done=1 and busy=0, then returns to IDLE.
  - start is ignored outside IDLE.
- X channel (in RUN):
  - x_valid=1 while x_cnt<SIZE_X; x_data = xbuf[x_cnt], combinational from the counter.
  - A beat transfers on x_valid&&x_ready, which increments x_cnt; back-to-back beats are allowed.
  - x_data and x_valid are stable while x_valid&&!x_ready.
  - After SIZE_X beats, x_valid=0.
- F channel: identical to X, using f_cnt, SIZE_F and fbuf. It is fully independent of X; there is no ordering between the two streams.
- Y channel (in RUN):
  - y_ready=1 while y_cnt<NUM_Y, including before the X/F streams have finished.
  - On y_valid&&y_ready, write rbuf[y_cnt]=y_data and increment y_cnt.
  - After NUM_Y results, y_ready=0; further y_valid beats are not accepted.
- Counters are $clog2(N+1) bits wide and never wrap; each saturates at its terminal count.
- res_data is registered: it follows rbuf[res_addr] one cycle later. Reads are allowed in any state.
  - A read of the index being written in the same cycle returns the old value.
  - An out-of-range res_addr returns 0.
- Simultaneous events: an X beat, an F beat and a Y beat in the same cycle are all accepted. A start coincident with cfg_wr_en in IDLE performs the write first, so the new value is the one transmitted.
- A reset asserted mid-run aborts the run immediately; valid/ready outputs drop the next cycle and no done pulse is issued.

Optional Feature:
- Macro: STALL_INJECT_EN.
- Defined:
  - An 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded to 8'hA5 on reset, advances every cycle in RUN.
  - A new X beat may only be presented when lfsr[0]=0; a new F beat only when lfsr[1]=0.
  - y_ready is additionally gated by lfsr[2]==0.
  - Once raised, a valid is never dropped before acceptance.
- Not defined: no LFSR; valids and y_ready follow the base rules with no throttling.

Test Plan:
- Load X=1..12 and F=1,0,0,0,0; start with x_ready=f_ready=1 and the DUT returning y_k=x_k -> beats transfer on 12 consecutive cycles (X) and 5 (F); rbuf[0..7]=1..8; done pulses once; busy falls in the same cycle done rises.
- Hold x_ready=0 for 3 cycles at beat 4 -> x_data stays at xbuf[4] and x_valid stays at 1; x_cnt ends at 12; no sample is duplicated or skipped.
- Present 9 y_valid beats -> only the first 8 are stored; y_ready=0 after the 8th; the 9th beat is not accepted.
- Assert reset at cycle 6 of RUN -> the next cycle shows busy=0 and x_valid=f_valid=y_ready=0; there is no done pulse; a fresh start re-sends from x_cnt=0.
- Issue a cfg write of 16'h3FF to X[0] while busy -> it is ignored; the next run transmits the original X[0]. start while busy is ignored.
- With STALL_INJECT_EN and a randomly ready convolver -> all 12/5/8 beats complete, there are no valid drops before acceptance, and results match the golden convolution.
